// File: rtl/elastic_stage_buffer_if.sv
// Handshake bundle around the elastic stage buffer.
// The master side is the pipeline environment. The slave side is the buffer itself.
interface elastic_stage_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             dis;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output data_in, in_valid, dis, flush, out_ready,
    input  in_ready, data_out, out_valid, count
  );

  modport slave (
    input  data_in, in_valid, dis, flush, out_ready,
    output in_ready, data_out, out_valid, count
  );
endinterface

// File: rtl/elastic_stage_buffer.sv
// Lockable circular-queue pipeline stage with valid/ready on both sides and synchronous flush.
// DEPTH=1 with both valids/readies held high behaves as a single stall/flush stage register.
module elastic_stage_buffer #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{1'b0}},
  localparam int              CNT_W     = $clog2(DEPTH + 1),
  localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input logic                  clk,
  input logic                  rst,
  elastic_stage_buffer_if.slave bus
);

  generate
    if (DEPTH < 1 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("elastic_stage_buffer: DEPTH must be a power of two in 1..8");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Pointers wrap at DEPTH-1; with DEPTH=1 they are pinned at zero.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    in_ready  = (count_q != CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    push      = bus.in_valid & in_ready & ~bus.flush;
    pop       = out_valid & bus.out_ready & ~bus.dis & ~bus.flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.data_out  = out_valid ? mem_q[rd_ptr_q] : FLUSH_VAL;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_elastic_stage_buffer.sv
// Directed table plus hand sequences for the elastic stage buffer (DEPTH=2),
// and a random comparison of a DEPTH=1 instance against a stall/flush register model.
module tb_elastic_stage_buffer;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  elastic_stage_buffer_if #(.WIDTH(16), .DEPTH(2)) ifa ();
  elastic_stage_buffer_if #(.WIDTH(16), .DEPTH(1)) ifb ();

  elastic_stage_buffer #(.WIDTH(16), .DEPTH(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  elastic_stage_buffer #(.WIDTH(16), .DEPTH(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  typedef struct {
    logic [15:0] din;
    logic        iv;
    logic        ordy;
    logic        dis;
    logic        fl;
    logic [1:0]  e_cnt;
    logic        e_ir;
    logic        e_ov;
    logic [15:0] e_dout;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [15:0] din, input logic iv, input logic ordy,
                              input logic dis, input logic fl, input logic [1:0] e_cnt,
                              input logic e_ir, input logic e_ov, input logic [15:0] e_dout);
    vec_t v;
    v.din = din; v.iv = iv; v.ordy = ordy; v.dis = dis; v.fl = fl;
    v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ov = e_ov; v.e_dout = e_dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] cnt, input logic ir,
                         input logic ov, input logic [15:0] dout);
    n_vec++;
    chk({tag, " count"},     ifa.count,     cnt);
    chk({tag, " in_ready"},  ifa.in_ready,  ir);
    chk({tag, " out_valid"}, ifa.out_valid, ov);
    chk({tag, " data_out"},  ifa.data_out,  dout);
  endtask

  task automatic drive_a(input logic [15:0] din, input logic iv, input logic ordy,
                         input logic dis, input logic fl);
    ifa.data_in = din; ifa.in_valid = iv; ifa.out_ready = ordy;
    ifa.dis = dis; ifa.flush = fl;
  endtask

  // Structural invariants: occupancy bounded, and out_valid tracks non-empty.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.count > 2'd2 || ifb.count > 1'b1) begin
        n_err++;
        $display("FAIL count_bound: a=%0d b=%0d", ifa.count, ifb.count);
      end
      if (ifa.out_valid !== (ifa.count != 0)) begin
        n_err++;
        $display("FAIL pop_when_empty: out_valid=%0b count=%0d", ifa.out_valid, ifa.count);
      end
    end
  end

  logic        ref_valid;
  logic [15:0] ref_data;
  logic        b_dis, b_fl;
  logic [15:0] b_din;

  initial begin
    vecs[0]  = mk(16'h1111, 1, 0, 0, 0, 2'd1, 1, 1, 16'h1111);
    vecs[1]  = mk(16'h2222, 1, 0, 0, 0, 2'd2, 0, 1, 16'h1111);
    vecs[2]  = mk(16'h3333, 1, 0, 0, 0, 2'd2, 0, 1, 16'h1111);
    vecs[3]  = mk(16'h3333, 1, 1, 0, 0, 2'd1, 1, 1, 16'h2222);
    vecs[4]  = mk(16'h0000, 0, 1, 0, 0, 2'd0, 1, 0, 16'h0000);
    vecs[5]  = mk(16'h0000, 0, 1, 0, 0, 2'd0, 1, 0, 16'h0000);
    vecs[6]  = mk(16'hABCD, 1, 0, 0, 0, 2'd1, 1, 1, 16'hABCD);
    vecs[7]  = mk(16'h0002, 1, 1, 1, 0, 2'd2, 0, 1, 16'hABCD);
    vecs[8]  = mk(16'h0003, 1, 1, 1, 0, 2'd2, 0, 1, 16'hABCD);
    vecs[9]  = mk(16'h0003, 1, 1, 1, 0, 2'd2, 0, 1, 16'hABCD);
    vecs[10] = mk(16'h0003, 1, 1, 0, 0, 2'd1, 1, 1, 16'h0002);
    vecs[11] = mk(16'h0003, 1, 1, 0, 0, 2'd1, 1, 1, 16'h0003);
    vecs[12] = mk(16'h0000, 0, 1, 0, 0, 2'd0, 1, 0, 16'h0000);
    vecs[13] = mk(16'h7777, 1, 1, 1, 0, 2'd1, 1, 1, 16'h7777);
    vecs[14] = mk(16'h0000, 0, 1, 1, 0, 2'd1, 1, 1, 16'h7777);
    vecs[15] = mk(16'h8888, 1, 0, 0, 0, 2'd2, 0, 1, 16'h7777);
    vecs[16] = mk(16'h5555, 1, 1, 1, 1, 2'd0, 1, 0, 16'h0000);
    vecs[17] = mk(16'h0000, 0, 1, 0, 0, 2'd0, 1, 0, 16'h0000);
    vecs[18] = mk(16'h0A0A, 1, 0, 0, 0, 2'd1, 1, 1, 16'h0A0A);
    vecs[19] = mk(16'h0000, 0, 1, 0, 0, 2'd0, 1, 0, 16'h0000);

    rst = 1'b1;
    drive_a(16'h0, 0, 0, 0, 0);
    ifb.data_in = '0; ifb.in_valid = 1'b0; ifb.out_ready = 1'b0;
    ifb.dis = 1'b0; ifb.flush = 1'b0;
    #12;
    check_a("reset", 2'd0, 1, 0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Fill/full, lock, flush and wrap through the table.
    for (int i = 0; i < NV; i++) begin
      drive_a(vecs[i].din, vecs[i].iv, vecs[i].ordy, vecs[i].dis, vecs[i].fl);
      @(posedge clk);
      #1;
      check_a($sformatf("v%0d", i), vecs[i].e_cnt, vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_dout);
    end

    // Streaming: each word is visible right after the edge that writes it.
    for (int w = 1; w <= 16; w++) begin
      drive_a(16'(w), 1, 1, 0, 0);
      @(posedge clk);
      #1;
      check_a($sformatf("stream%0d", w), 2'd1, 1, 1, 16'(w));
    end
    drive_a(16'h0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_a("stream_drain", 2'd0, 1, 0, 16'h0000);

    // Asynchronous reset with two entries stored, checked before any clock edge.
    drive_a(16'h4444, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    drive_a(16'h4545, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check_a("pre_rst", 2'd2, 0, 1, 16'h4444);
    drive_a(16'h0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_a("async_rst", 2'd0, 1, 0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // DEPTH=1 with both valids high against a stall/flush register model.
    ref_valid = 1'b0;
    ref_data  = '0;
    ifb.in_valid  = 1'b1;
    ifb.out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      b_din = 16'($urandom);
      b_dis = 1'($urandom_range(0, 1));
      b_fl  = ($urandom_range(0, 15) == 0);
      ifb.data_in = b_din;
      ifb.dis     = b_dis;
      ifb.flush   = b_fl;
      @(posedge clk);
      if (b_fl) begin
        ref_valid = 1'b0;
      end else if (!ref_valid) begin
        ref_valid = 1'b1;
        ref_data  = b_din;
      end else if (!b_dis) begin
        ref_valid = 1'b0;
      end
      #1;
      n_vec++;
      chk($sformatf("legacy%0d out_valid", c), ifb.out_valid, ref_valid);
      chk($sformatf("legacy%0d data_out", c), ifb.data_out, ref_valid ? ref_data : 16'h0000);
      chk($sformatf("legacy%0d count", c), ifb.count, ref_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
